// File: rtl/thrusters_pkg.sv
// thrusters_pkg: shared controller state encoding and helpers for the Thrusters plant.
package thrusters_pkg;
    localparam int N_DEF = 4;
    typedef enum logic [2:0] {IDLE, ALIGN, KICK, BRAKE, DONE, FAULT} state_e;
    function automatic logic [31:0] signed_abs(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return (((v >> (n - 1)) & 32'd1) != 32'd0) ? (~v + 32'd1) & m : v & m;
    endfunction
    function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/attitude_controller_angle_error.sv
// angle_error: shortest modular path from angle to target as sign and magnitude.
module angle_error import thrusters_pkg::*; #(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] target_i,
    input  logic [N-1:0] angle_i,
    output logic         neg_o,
    output logic [N-1:0] mag_o
);
    logic [N-1:0] diff;
    assign diff  = target_i - angle_i;
    assign neg_o = diff[N-1];
    assign mag_o = N'(signed_abs(32'(diff), N));
endmodule

// File: rtl/attitude_controller.sv
// attitude_controller: drives Thrusters in kick/brake steps until angle hits target at rest.
module attitude_controller import thrusters_pkg::*; #(
    parameter int N           = N_DEF,
    parameter int WDOG_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [N-1:0] cmd_target_i,
    input  logic [N-1:0] cmd_thrust_i,
    input  logic [N-1:0] angle_i,
    input  logic [N-1:0] velocity_i,
    output logic         up_o,
    output logic         down_o,
    output logic [N-1:0] thrust_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         fault_o
);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
    state_e        state_q;
    logic [N-1:0]  tgt_q, thr_q, mag_q;
    logic          dir_q;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_neg, move, active, accept;
    logic [N-1:0]  err_mag, vel_mag, step_mag;
    angle_error #(.N(N)) u_err (
        .target_i (tgt_q),
        .angle_i  (angle_i),
        .neg_o    (err_neg),
        .mag_o    (err_mag)
    );
    assign vel_mag     = N'(signed_abs(32'(velocity_i), N));
    assign step_mag    = N'(min_u(32'(thr_q), 32'(err_mag)));
    assign move        = (state_q == KICK) || (state_q == BRAKE);
    assign active      = state_q inside {ALIGN, KICK, BRAKE};
    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign fault_o     = state_q == FAULT;
    assign up_o        = move & dir_q;
    assign down_o      = move & ~dir_q;
    assign thrust_o    = move ? mag_q : '0;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign wdog_d      = accept ? '0 : busy_o ? wdog_q + 1'b1 : wdog_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            thr_q   <= '0;
            mag_q   <= '0;
            dir_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            if (active && wdog_q == WD_LAST) begin
                state_q <= FAULT;
            end else begin
                case (state_q)
                    IDLE: if (cmd_valid_i) begin
                        tgt_q   <= cmd_target_i;
                        thr_q   <= (cmd_thrust_i == '0) ? N'(1) : cmd_thrust_i;
                        state_q <= ALIGN;
                    end
                    // A moving plant is always braked to rest before measuring error.
                    ALIGN: if (velocity_i != '0) begin
                        mag_q   <= vel_mag;
                        dir_q   <= velocity_i[N-1];
                        state_q <= BRAKE;
                    end else if (err_mag == '0) begin
                        state_q <= DONE;
                    end else begin
                        mag_q   <= step_mag;
                        dir_q   <= ~err_neg;
                        state_q <= KICK;
                    end
                    KICK: begin
                        dir_q   <= ~dir_q;
                        state_q <= BRAKE;
                    end
                    BRAKE:   state_q <= ALIGN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_attitude_controller.sv
// tb_attitude_controller: directed checks of attitude_controller closing the loop on a Thrusters model.
module tb_attitude_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_target, cmd_thrust;
    logic [3:0] p_ang, p_vel;
    logic       up, down, busy, done, fault;
    logic [3:0] thrust;
    logic       ld, frz;
    logic [3:0] ld_a, ld_v;
    int         total = 0, bad = 0;
    int         lat, nsteps;
    bit         saw_done, saw_fault, both;
    logic [5:0] steps [64];

    attitude_controller #(.N(4), .WDOG_CYCLES(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_target_i (cmd_target),
        .cmd_thrust_i (cmd_thrust),
        .angle_i      (p_ang),
        .velocity_i   (p_vel),
        .up_o         (up),
        .down_o       (down),
        .thrust_o     (thrust),
        .busy_o       (busy),
        .done_o       (done),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    // Thrusters: angle integrates velocity, velocity integrates signed thrust.
    always @(posedge clk) begin
        if (ld) begin
            p_ang <= ld_a;
            p_vel <= ld_v;
        end else if (!frz) begin
            p_ang <= p_ang + p_vel;
            p_vel <= p_vel + (up ? thrust : 4'd0) - (down ? thrust : 4'd0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [3:0] a, input logic [3:0] v);
        @(negedge clk);
        ld = 1'b1; ld_a = a; ld_v = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] tg, input logic [3:0] th);
        lat = 0; nsteps = 0; saw_done = 0; saw_fault = 0; both = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = tg; cmd_thrust = th;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_target = ~tg; cmd_thrust = 4'd7;
        chk("acc_busy", busy, 1);
        chk("acc_ready", cmd_ready, 0);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (up & down) both = 1;
            if ((up | down) && nsteps < 64) begin
                steps[nsteps] = {up, down, thrust};
                nsteps++;
            end
            if (done) begin saw_done = 1; lat = c; break; end
            if (fault) begin saw_fault = 1; lat = c; break; end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_thrust = '0;
        ld = 1'b0; frz = 1'b0; ld_a = '0; ld_v = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {up, down, thrust}, 0);
        chk("rst_pulses", {done, fault}, 0);
        @(negedge clk); rst_n = 1'b1;

        // mid-KICK reset drops the command immediately
        preset(4'd0, 4'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 4'd5; cmd_thrust = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && !up; c++) begin
            @(posedge clk); #1;
        end
        chk("kick_seen", {up, thrust}, {1'b1, 4'd3});
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {up, down, thrust}, 0);
        chk("midrst_busy", busy, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_ready", cmd_ready, 1);

        // basic two-step approach
        preset(4'd0, 4'd0);
        run_cmd(4'd5, 4'd3);
        chk("t2_lat", lat, 7);
        chk("t2_done", {saw_done, saw_fault}, 2'b10);
        chk("t2_pos", {p_ang, p_vel}, {4'd5, 4'd0});
        chk("t2_nsteps", nsteps, 4);
        chk("t2_s0", steps[0], {1'b1, 1'b0, 4'd3});
        chk("t2_s1", steps[1], {1'b0, 1'b1, 4'd3});
        chk("t2_s2", steps[2], {1'b1, 1'b0, 4'd2});
        chk("t2_s3", steps[3], {1'b0, 1'b1, 4'd2});
        chk("t2_both", both, 0);
        @(posedge clk); #1;
        chk("t2_idle", {busy, cmd_ready, done}, 3'b010);

        // wrap-around forward path 14 -> 0 -> 1
        preset(4'd14, 4'd0);
        run_cmd(4'd1, 4'd2);
        chk("t3_lat", lat, 7);
        chk("t3_pos", {p_ang, p_vel}, {4'd1, 4'd0});
        chk("t3_k0", steps[0], {1'b1, 1'b0, 4'd2});
        chk("t3_k1", steps[2], {1'b1, 1'b0, 4'd1});

        // half-turn error resolves downwards 0 -> 12 -> 8
        preset(4'd0, 4'd0);
        run_cmd(4'd8, 4'd4);
        chk("t4_lat", lat, 7);
        chk("t4_pos", {p_ang, p_vel}, {4'd8, 4'd0});
        chk("t4_k0", steps[0], {1'b0, 1'b1, 4'd4});
        chk("t4_k1", steps[2], {1'b0, 1'b1, 4'd4});

        // spinning start, zero thrust treated as one: brake at 8, then six unit steps back to 2
        preset(4'd0, 4'd2);
        run_cmd(4'd2, 4'd0);
        chk("t5_lat", lat, 21);
        chk("t5_done", saw_done, 1);
        chk("t5_pos", {p_ang, p_vel}, {4'd2, 4'd0});
        chk("t5_brake", steps[0], {1'b0, 1'b1, 4'd2});
        chk("t5_k0", steps[1], {1'b0, 1'b1, 4'd1});
        chk("t5_b0", steps[2], {1'b1, 1'b0, 4'd1});
        chk("t5_both", both, 0);

        // stuck plant trips the watchdog
        preset(4'd0, 4'd0);
        frz = 1'b1;
        run_cmd(4'd4, 4'd1);
        chk("t6_fault", {saw_fault, saw_done}, 2'b10);
        chk("t6_lat", lat, 64);
        chk("t6_outs", {up, down, thrust}, 0);
        @(posedge clk); #1;
        chk("t6_idle", {busy, cmd_ready, fault}, 3'b010);
        frz = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
